mem_line_ctrl: RTL and testbench

Off-chip main-memory model and controller that sits directly downstream of the CPU's data-cache memory port. It accepts one 256-bit cache-line request at a time from `dcache_top` (`mem_enable_o`/`mem_write_o`/`mem_addr_o`/`mem_data_o`). It then waits a fixed access latency and answers with a one-cycle `ack_o`, plus read data for loads. Line storage is an internal array.

---
 rtl/mem_line_ctrl.sv | 92 +++++++++
 tb/tb_mem_line_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_line_ctrl.sv
// Off-chip main-memory model for the data-cache line port: one 256-bit line
// request at a time, answered after a fixed latency with a single-cycle ack.
module mem_line_ctrl #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [IDX_W-1:0]  req_idx;
  logic              req_write;
  logic [LINE_W-1:0] req_data;
  logic              done;

  logic [LINE_W-1:0] mem [DEPTH];

  // Offset bits and address bits above the line index are deliberately dropped,
  // so addresses wrap modulo DEPTH lines.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  assign done = (state == S_BUSY) && (cnt == LAST_CNT);

  // NOTE: all state registers use non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ack_o     <= 1'b0;
      busy_o    <= 1'b0;
      data_o    <= '0;
      req_idx   <= '0;
      req_write <= 1'b0;
      req_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable_i) begin
            req_idx   <= addr_i[IDX_W+4:5];
            req_write <= write_i;
            req_data  <= data_i;
            cnt       <= '0;
            busy_o    <= 1'b1;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt + 8'd1;
          if (done) begin
            ack_o <= 1'b1;
            state <= S_ACK;
            if (!req_write) data_o <= mem[req_idx];
          end
        end
        S_ACK: begin
          ack_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the line array has no reset; clearing it would turn it into a huge
  // register bank. Reset only has to suppress a pending write here.
  always_ff @(posedge clk_i) begin
    if (!rst_i && done && req_write) mem[req_idx] <= req_data;
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed self-checking bench for mem_line_ctrl: latency, data path,
// address wrap, held enable, input isolation and mid-operation reset.
module tb_mem_line_ctrl;

  localparam int LW  = 256;
  localparam int LAT = 10;

  logic          clk_i;
  logic          rst_i;
  logic          enable_i;
  logic          write_i;
  logic [31:0]   addr_i;
  logic [LW-1:0] data_i;
  logic          ack_o;
  logic [LW-1:0] data_o;
  logic          busy_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [LW-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] PAT_D  = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [LW-1:0] PAT_W  = {8{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] PAT_L1 = {16{16'h1111}};
  localparam logic [LW-1:0] PAT_L2 = {16{16'h2222}};
  localparam logic [LW-1:0] PAT_L5 = {16{16'h5555}};
  localparam logic [LW-1:0] PAT_L7 = {16{16'h7777}};
  localparam logic [LW-1:0] PAT_L9 = {16{16'h9999}};
  localparam logic [LW-1:0] PAT_N  = {16{16'hC0DE}};

  mem_line_ctrl #(.LINE_W(LW), .DEPTH(512), .LATENCY(LAT)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o),
    .busy_o   (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full request; inputs are scrambled after acceptance and addr_i is
  // switched to a_late in cycle 3 to prove they are ignored while busy.
  task automatic req(input string tag, input logic w, input logic [31:0] a,
                     input logic [LW-1:0] d, input logic [31:0] a_late);
    int ack_at;
    int ack_cnt;
    int busy_bad;
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = w;
    addr_i   = a;
    data_i   = d;
    ack_at   = -1;
    ack_cnt  = 0;
    busy_bad = 0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        enable_i = 1'b0;
        write_i  = ~w;
        data_i   = ~d;
      end
      if (c == 3) addr_i = a_late;
      if (!busy_o) busy_bad++;
      if (ack_o) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = c;
      end
    end
    check({tag, "_ack_cycle"}, LW'(ack_at), LW'(LAT));
    check({tag, "_ack_count"}, LW'(ack_cnt), LW'(1));
    check({tag, "_busy_window"}, LW'(busy_bad), LW'(0));
    @(negedge clk_i);
    write_i = 1'b0;
    check({tag, "_idle_after"}, LW'({busy_o, ack_o}), LW'(0));
  endtask

  initial begin
    logic [31:0] ack_mask;
    int          ack_cnt;

    rst_i    = 1'b1;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    repeat (3) @(negedge clk_i);
    check("reset_ack", LW'(ack_o), LW'(0));
    check("reset_busy", LW'(busy_o), LW'(0));
    check("reset_data", data_o, '0);
    rst_i = 1'b0;

    // Preload through the write port.
    req("pre3", 1'b1, 32'h60, PAT_A5, 32'h60);
    check("data_after_first_write", data_o, '0);
    req("pre1", 1'b1, 32'h20, PAT_L1, 32'h20);
    req("pre2", 1'b1, 32'h40, PAT_L2, 32'h40);
    req("pre5", 1'b1, 32'hA0, PAT_L5, 32'hA0);
    req("pre7", 1'b1, 32'hE0, PAT_L7, 32'hE0);
    req("pre9", 1'b1, 32'h120, PAT_L9, 32'h120);

    req("rd3", 1'b0, 32'h60, '0, 32'h60);
    check("rd3_data", data_o, PAT_A5);

    req("wr15", 1'b1, 32'h1E0, PAT_D, 32'h1E0);
    check("wr15_data_unchanged", data_o, PAT_A5);
    req("rd15", 1'b0, 32'h1E7, '0, 32'h1E7);
    check("rd15_data", data_o, PAT_D);

    req("wr_wrap", 1'b1, 32'h4000, PAT_W, 32'h4000);
    req("rd0", 1'b0, 32'h0, '0, 32'h0);
    check("rd0_wrap_data", data_o, PAT_W);

    req("rd7", 1'b0, 32'hE0, '0, 32'h120);
    check("rd7_addr_change", data_o, PAT_L7);

    // Held enable: reads of line 1 then line 2 back to back.
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = 1'b0;
    addr_i   = 32'h20;
    ack_mask = '0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk_i);
      if (c == 1) addr_i = 32'h40;
      if (c == 21) enable_i = 1'b0;
      if (ack_o) ack_mask[c] = 1'b1;
      if (c == 10) check("held_first_data", data_o, PAT_L1);
      if (c == 11) check("held_idle_gap", LW'(busy_o), LW'(0));
      if (c == 12) check("held_second_accept", LW'(busy_o), LW'(1));
      if (c == 21) check("held_second_data", data_o, PAT_L2);
    end
    check("held_ack_cycles", LW'(ack_mask), LW'((32'd1 << 10) | (32'd1 << 21)));
    check("held_idle_end", LW'(busy_o), LW'(0));

    // Reset in cycle 6 of a write to line 5.
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'hA0;
    data_i   = PAT_N;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      if (c == 1) enable_i = 1'b0;
      if (c == 6) rst_i = 1'b1;
    end
    @(negedge clk_i);
    check("rst_busy", LW'(busy_o), LW'(0));
    check("rst_ack", LW'(ack_o), LW'(0));
    check("rst_data", data_o, '0);
    rst_i   = 1'b0;
    write_i = 1'b0;
    ack_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (ack_o || busy_o) ack_cnt++;
    end
    check("rst_no_ack", LW'(ack_cnt), LW'(0));
    req("rd5", 1'b0, 32'hA0, '0, 32'hA0);
    check("rd5_preserved", data_o, PAT_L5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
